// File: rtl/shift_seq_ctrl.sv
// Sequencer for a WIDTH-bit left-shift register: load, timed shift strobes, done pulse.
// Optional SHIFT_SEQ_LOOP_EN: DONE reloads and repeats the sequence until stop.
module shift_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] pattern,
  input  logic [7:0]       steps,
  input  logic [DIV_W-1:0] period,
  input  logic [WIDTH-1:0] sr_q,
  output logic [WIDTH-1:0] sr_d,
  output logic             sr_l,
  output logic             sr_en,
  output logic             sr_load,
  output logic             busy,
  output logic             done,
  output logic [7:0]       step_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] per_r;
  logic [WIDTH-1:0] pat_r;
  logic [1:0]       mode_r;
  logic [7:0]       steps_r;
  logic             alt;

  logic last_step;
  logic per_one;
  logic div_end;

  assign last_step = ((step_cnt + 8'd1) == steps_r);
  assign per_one   = (per_r == DIV_W'(1));
  // WAIT spans P-1 cycles, so the strobe lands exactly P cycles after the previous one.
  assign div_end   = (div == (per_r - DIV_W'(2)));

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_LOAD;
      S_LOAD: begin
        if (stop)                 state_nxt = S_IDLE;
        else if (steps_r == 8'd0) state_nxt = S_DONE;
        else if (per_one)         state_nxt = S_SHIFT;
        else                      state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (stop)         state_nxt = S_IDLE;
        else if (div_end) state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        if (stop)           state_nxt = S_IDLE;
        else if (last_step) state_nxt = S_DONE;
        else if (per_one)   state_nxt = S_SHIFT;
        else                state_nxt = S_WAIT;
      end
`ifdef SHIFT_SEQ_LOOP_EN
      S_DONE:  state_nxt = S_LOAD;
`else
      S_DONE:  state_nxt = S_IDLE;
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      div      <= '0;
      per_r    <= '0;
      pat_r    <= '0;
      mode_r   <= '0;
      steps_r  <= '0;
      step_cnt <= '0;
      alt      <= 1'b1;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (start) begin
            pat_r    <= pattern;
            mode_r   <= mode;
            steps_r  <= steps;
            per_r    <= (period == '0) ? DIV_W'(1) : period;
            step_cnt <= '0;
            alt      <= 1'b1;
          end
        end
        S_SHIFT: begin
          if (step_cnt != steps_r) step_cnt <= step_cnt + 8'd1;
          alt <= ~alt;
        end
`ifdef SHIFT_SEQ_LOOP_EN
        S_DONE: begin
          step_cnt <= '0;
          alt      <= 1'b1;
        end
`endif
        default: ;
      endcase
      if (state_nxt == S_WAIT && state != S_WAIT) div <= '0;
      else if (state == S_WAIT)                   div <= div + DIV_W'(1);
    end
  end

  assign sr_d    = pat_r;
  assign sr_en   = (state == S_LOAD) || (state == S_SHIFT);
  assign sr_load = (state == S_LOAD);
  assign busy    = (state == S_LOAD) || (state == S_WAIT) || (state == S_SHIFT);
  assign done    = (state == S_DONE);

  // Rotate mode is the only input-to-output combinational path.
  always_comb begin
    sr_l = 1'b0;
    if (state == S_SHIFT) begin
      case (mode_r)
        2'd0:    sr_l = 1'b0;
        2'd1:    sr_l = 1'b1;
        2'd2:    sr_l = sr_q[WIDTH-1];
        default: sr_l = alt;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed self-checking bench for shift_seq_ctrl with a behavioural shift-register model on sr_q.
module tb_shift_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [1:0]  mode = '0;
  logic [7:0]  pattern = '0;
  logic [7:0]  steps = '0;
  logic [15:0] period = '0;
  logic [7:0]  sr_q;
  logic [7:0]  sr_d;
  logic        sr_l, sr_en, sr_load, busy, done;
  logic [7:0]  step_cnt;

  logic [7:0]  q_model;
  int          checks = 0;
  int          passed = 0;
  logic [63:0] strobe_m, load_m, done_m;
  logic [15:0] sl_bits;
  int          busy_n;

  shift_seq_ctrl #(.WIDTH(8), .DIV_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
    .pattern(pattern), .steps(steps), .period(period), .sr_q(sr_q),
    .sr_d(sr_d), .sr_l(sr_l), .sr_en(sr_en), .sr_load(sr_load),
    .busy(busy), .done(done), .step_cnt(step_cnt)
  );

  always #5 clk = ~clk;

  // External shift register being sequenced
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)     q_model <= '0;
    else if (sr_en) q_model <= sr_load ? sr_d : {q_model[6:0], sr_l};
  end
  assign sr_q = q_model;

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leaves the bench in the LOAD cycle with inputs scrambled.
  task automatic start_seq(input logic [7:0] pat, input logic [1:0] md,
                           input logic [7:0] st, input logic [15:0] per);
    pattern = pat; mode = md; steps = st; period = per; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; pattern = ~pat; mode = ~md; steps = 8'hFF; period = 16'd7;
  endtask

  task automatic capture(input int ncyc, input int stop_at);
    strobe_m = '0; load_m = '0; done_m = '0; sl_bits = '0; busy_n = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (c == stop_at + 1) stop = 1'b0;
      if (sr_en && sr_load) load_m[c] = 1'b1;
      if (sr_en && !sr_load) begin
        strobe_m[c] = 1'b1;
        sl_bits = {sl_bits[14:0], sr_l};
      end
      if (busy) busy_n++;
      if (done) done_m[c] = 1'b1;
      if (c == stop_at) stop = 1'b1;
      @(posedge clk); #1;
    end
    stop = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b1; pattern = 8'h5A; steps = 8'd3; period = 16'd1; mode = 2'd1;
    idle(3);
    checks++; if ({sr_d, sr_l, sr_en, sr_load, busy, done, step_cnt} !== 21'h0)
      $display("FAIL reset_outputs: got %h want 0", {sr_d, sr_l, sr_en, sr_load, busy, done, step_cnt}); else passed++;
    start = 1'b0;
    rst_n = 1'b1;
    idle(2);
    checks++; if ({busy, sr_en} !== 2'b00)
      $display("FAIL reset_idle: got busy/en %b want 00", {busy, sr_en}); else passed++;
  endtask

  task automatic test_basic;
    start_seq(8'h81, 2'd0, 8'd3, 16'd1);
    capture(8, -1);
    checks++; if (load_m !== 64'h1) $display("FAIL basic_load: got %h want 1", load_m); else passed++;
    checks++; if (strobe_m !== 64'hE) $display("FAIL basic_strobes: got %h want e", strobe_m); else passed++;
    checks++; if (sl_bits !== 16'h0) $display("FAIL basic_sl: got %h want 0", sl_bits); else passed++;
    checks++; if (done_m !== 64'h10) $display("FAIL basic_done: got %h want 10", done_m); else passed++;
    checks++; if (busy_n !== 4) $display("FAIL basic_busy: got %0d want 4", busy_n); else passed++;
    checks++; if (q_model !== 8'h08) $display("FAIL basic_q: got %h want 08", q_model); else passed++;
    checks++; if (step_cnt !== 8'd3) $display("FAIL basic_cnt: got %0d want 3", step_cnt); else passed++;
    checks++; if (sr_d !== 8'h81) $display("FAIL basic_sr_d: got %h want 81", sr_d); else passed++;
  endtask

  task automatic test_period;
    start_seq(8'h01, 2'd1, 8'd4, 16'd5);
    capture(26, -1);
    checks++; if (strobe_m !== 64'h108420) $display("FAIL period_strobes: got %h want 108420", strobe_m); else passed++;
    checks++; if (sl_bits !== 16'hF) $display("FAIL period_sl: got %h want f", sl_bits); else passed++;
    checks++; if (done_m !== 64'h200000) $display("FAIL period_done: got %h want 200000", done_m); else passed++;
    checks++; if (busy_n !== 21) $display("FAIL period_busy: got %0d want 21", busy_n); else passed++;
    checks++; if (q_model !== 8'h1F) $display("FAIL period_q: got %h want 1f", q_model); else passed++;
    checks++; if (step_cnt !== 8'd4) $display("FAIL period_cnt: got %0d want 4", step_cnt); else passed++;
  endtask

  task automatic test_rotate;
    start_seq(8'hA5, 2'd2, 8'd8, 16'd2);
    capture(20, -1);
    checks++; if (strobe_m !== 64'h15554) $display("FAIL rotate_strobes: got %h want 15554", strobe_m); else passed++;
    checks++; if (sl_bits !== 16'hA5) $display("FAIL rotate_sl: got %h want a5", sl_bits); else passed++;
    checks++; if (done_m !== 64'h20000) $display("FAIL rotate_done: got %h want 20000", done_m); else passed++;
    checks++; if (q_model !== 8'hA5) $display("FAIL rotate_q: got %h want a5", q_model); else passed++;
  endtask

  task automatic test_alternate;
    start_seq(8'h00, 2'd3, 8'd4, 16'd0);
    capture(8, -1);
    checks++; if (strobe_m !== 64'h1E) $display("FAIL alt_strobes: got %h want 1e", strobe_m); else passed++;
    checks++; if (sl_bits !== 16'hA) $display("FAIL alt_sl: got %h want a", sl_bits); else passed++;
    checks++; if (done_m !== 64'h20) $display("FAIL alt_done: got %h want 20", done_m); else passed++;
    checks++; if (q_model !== 8'h0A) $display("FAIL alt_q: got %h want 0a", q_model); else passed++;
  endtask

  task automatic test_zero_steps;
    start_seq(8'h3C, 2'd1, 8'd0, 16'd1);
    capture(4, -1);
    checks++; if (load_m !== 64'h1) $display("FAIL zero_load: got %h want 1", load_m); else passed++;
    checks++; if (strobe_m !== 64'h0) $display("FAIL zero_strobes: got %h want 0", strobe_m); else passed++;
    checks++; if (done_m !== 64'h2) $display("FAIL zero_done: got %h want 2", done_m); else passed++;
    checks++; if (busy_n !== 1) $display("FAIL zero_busy: got %0d want 1", busy_n); else passed++;
  endtask

  task automatic test_stop;
    start_seq(8'hC3, 2'd1, 8'd6, 16'd3);
    capture(12, 7);
    checks++; if (strobe_m !== 64'h48) $display("FAIL stop_strobes: got %h want 48", strobe_m); else passed++;
    checks++; if (done_m !== 64'h0) $display("FAIL stop_done: got %h want 0", done_m); else passed++;
    checks++; if (step_cnt !== 8'd2) $display("FAIL stop_cnt: got %0d want 2", step_cnt); else passed++;
    checks++; if (busy_n !== 8) $display("FAIL stop_busy_n: got %0d want 8", busy_n); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL stop_idle: got busy %b want 0", busy); else passed++;
    checks++; if (q_model !== 8'h0F) $display("FAIL stop_q: got %h want 0f", q_model); else passed++;
  endtask

`ifdef SHIFT_SEQ_LOOP_EN
  task automatic test_loop;
    start_seq(8'h11, 2'd0, 8'd2, 16'd1);
    capture(14, 13);
    checks++; if (load_m !== 64'h1111) $display("FAIL loop_load: got %h want 1111", load_m); else passed++;
    checks++; if (done_m !== 64'h888) $display("FAIL loop_done: got %h want 888", done_m); else passed++;
    checks++; if (strobe_m !== 64'h2666) $display("FAIL loop_strobes: got %h want 2666", strobe_m); else passed++;
    checks++; if ({busy, step_cnt} !== 9'h001) $display("FAIL loop_stop: got %h want 001", {busy, step_cnt}); else passed++;
    idle(3);
  endtask
`else
  task automatic test_back_to_back;
    pattern = 8'h11; mode = 2'd0; steps = 8'd1; period = 16'd1; start = 1'b1;
    @(posedge clk); #1;
    capture(8, -1);
    start = 1'b0;
    checks++; if (load_m !== 64'h11) $display("FAIL b2b_load: got %h want 11", load_m); else passed++;
    checks++; if (strobe_m !== 64'h22) $display("FAIL b2b_strobes: got %h want 22", strobe_m); else passed++;
    checks++; if (done_m !== 64'h44) $display("FAIL b2b_done: got %h want 44", done_m); else passed++;
    idle(4);
  endtask
`endif

  task automatic test_reset_mid;
    start_seq(8'h3C, 2'd1, 8'd4, 16'd5);
    idle(7);
    checks++; if ({busy, step_cnt} !== 9'h101) $display("FAIL midrst_pre: got %h want 101", {busy, step_cnt}); else passed++;
    #3 rst_n = 1'b0;
    #1;
    checks++; if ({sr_d, sr_l, sr_en, sr_load, busy, done, step_cnt} !== 21'h0)
      $display("FAIL midrst_async: got %h want 0", {sr_d, sr_l, sr_en, sr_load, busy, done, step_cnt}); else passed++;
    #2 rst_n = 1'b1;
    idle(2);
    checks++; if ({busy, sr_en, done} !== 3'b000) $display("FAIL midrst_idle: got %b want 000", {busy, sr_en, done}); else passed++;
  endtask

  initial begin
    test_reset;
    test_basic;
    idle(2);
    test_period;
    test_rotate;
    test_alternate;
    test_zero_steps;
    test_stop;
`ifdef SHIFT_SEQ_LOOP_EN
    test_loop;
`else
    test_back_to_back;
`endif
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
- Sequencer for an 8-bit left-shift register with parallel load, enable and serial-in. The register's ports are D, L, en, load and Q.
- On a start request it does three things:
  - loads a parallel pattern;
  - issues a programmed number of shift strobes at a programmable interval, with the serial-in bit chosen by mode;
  - reports completion with a one-cycle done pulse.
- Sits between the user/LED sequencing logic and the shift register datapath.

Parameters:
- WIDTH, 8, shift register width; also the width of sr_d and sr_q.
- DIV_W, 16, width of the interval divider and of the period port.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- start  input  1  begin a sequence; sampled only in IDLE.
- stop  input  1  abort the current sequence; sampled in any busy state.
- mode  input  2  serial-in select: 0 = zeros, 1 = ones, 2 = rotate, 3 = alternate 1/0.
- pattern  input  WIDTH  value loaded into the shift register.
- steps  input  8  number of shift strobes (0..255).
- period  input  DIV_W  cycles between strobes; 0 is treated as 1.
- sr_q  input  WIDTH  current shift register Q, used for rotate.
- sr_d  output  WIDTH  parallel data to the register.
- sr_l  output  1  serial-in bit to the register.
- sr_en  output  1  register enable.
- sr_load  output  1  register load select.
- busy  output  1  high in LOAD, WAIT and SHIFT.
- done  output  1  one-cycle pulse on normal completion.
- step_cnt  output  8  number of shift strobes issued so far in the current or last sequence.

Behaviour:
- States: IDLE, LOAD, WAIT, SHIFT, DONE. All outputs are a decode of registered state and counters; no combinational path from inputs to outputs except sr_l in rotate mode (sr_l = sr_q[WIDTH-1]).
- Reset (async): state = IDLE, divider = 0, step_cnt = 0, alt toggle = 1, captured regs = 0. All outputs 0.
- IDLE:
  - sr_en = 0, sr_load = 0, busy = 0.
  - If start = 1: capture pattern, mode, steps and P = max(period, 1), clear step_cnt, set alt toggle = 1, go to LOAD.
  - Inputs changing after capture have no effect until the next start.
- LOAD (1 cycle):
  - sr_en = 1, sr_load = 1, sr_d = captured pattern.
  - If steps = 0, go to DONE.
  - Else if P = 1, go to SHIFT; otherwise go to WAIT with divider = 0.
- WAIT (P-1 cycles):
  - sr_en = 0.
  - Divider increments each cycle; when divider = P-2, go to SHIFT.
- SHIFT (1 cycle):
  - sr_en = 1, sr_load = 0, sr_l per mode:
    - mode 0: 0;
    - mode 1: 1;
    - mode 2: sr_q[WIDTH-1];
    - mode 3: alt toggle, which then inverts.
  - step_cnt increments.
  - If step_cnt+1 = steps, go to DONE. Else go to WAIT (divider = 0), or straight back to SHIFT if P = 1.
- DONE (1 cycle): done = 1, busy = 0, then go to IDLE.
- Timing:
  - Load strobe occurs the cycle after start is sampled.
  - The first shift strobe is exactly P cycles after the load strobe.
  - Consecutive shift strobes are exactly P cycles apart.
  - done is asserted the cycle after the last strobe, or the cycle after the load strobe when steps = 0.
- sr_d holds the captured pattern in all states; sr_l = 0 outside SHIFT.
- stop = 1 in LOAD, WAIT or SHIFT: the strobe of that cycle is still issued. Next state is IDLE, with no done pulse, and step_cnt is kept.
- stop has priority over DONE transitions; stop in IDLE or DONE has no effect.
- start while busy is ignored. start asserted in the DONE cycle is ignored; start is accepted only in IDLE.
- step_cnt saturates at steps and never wraps.
- Reset mid-sequence aborts immediately to the reset values.

Optional Feature:
- Macro SHIFT_SEQ_LOOP_EN.
- When defined:
  - the DONE state goes to LOAD (reloading the captured pattern and clearing step_cnt) instead of IDLE;
  - the sequence repeats indefinitely, with done pulsing once per pass;
  - only stop or reset returns the block to IDLE;
  - the alt toggle resets to 1 on each pass.
- When undefined: DONE always goes to IDLE, as described above.

Test Plan:
- Reset with start = 1 held → all outputs 0, state stays IDLE until rst_n deasserts. Then start with pattern = 8'h81, mode = 0, steps = 3, period = 1 → load strobe, then 3 consecutive shift strobes with sr_l = 0, done 1 cycle later. Modelled register Q sequence: 81, 02, 04, 08.
- pattern = 8'h01, mode = 1, steps = 4, period = 5 → strobes exactly 5 cycles apart, busy high for 1+20 cycles, final Q = 8'h1F, step_cnt = 4.
- pattern = 8'hA5, mode = 2, steps = 8, period = 2 → Q rotates back to 8'hA5 after 8 strobes, done pulses once.
- mode = 3, pattern = 8'h00, steps = 4, period = 0 → treated as period 1, sr_l sequence 1, 0, 1, 0, final Q = 8'h0A.
- steps = 0 → load strobe then done the next cycle, no shift strobe. stop asserted after 2 of 6 strobes (period = 3) → no further strobes, no done, step_cnt = 2, back in IDLE.
- With SHIFT_SEQ_LOOP_EN: steps = 2, period = 1 → done pulses every 4 cycles (LOAD, SHIFT, SHIFT, DONE) until stop. rst_n pulsed mid-WAIT → outputs 0 asynchronously.
